// File: rtl/RV32I_definitions.sv
// Shared RV32I definitions: regfile clear-FSM state type, default regfile
// geometry and an address range helper.
package RV32I_definitions;

    localparam int REG_DATA_WIDTH_DEF     = 32;
    localparam int REGFILE_ADDR_WIDTH_DEF = 5;
    localparam int REGFILE_DEPTH_DEF      = 32;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_IDLE  = 1'b1
    } regfile_state_t;

    // Range check done in 32 bits so DEPTH == 2**ADDR_WIDTH needs no special case.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/id_regfile_clear_seq.sv
// Sequential clear engine for id_regfile_mp: walks every entry once after
// reset or on Clear_req, then parks in RF_IDLE.
module id_regfile_clear_seq
    import RV32I_definitions::*;
#(
    parameter int REGFILE_DEPTH = REGFILE_DEPTH_DEF,
    parameter int CNT_WIDTH     = $clog2(REGFILE_DEPTH)
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Clear_req,
    output logic                 Clear_busy,
    output logic [CNT_WIDTH-1:0] clear_addr,
    output regfile_state_t       state
);

    regfile_state_t       state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RF_CLEAR: begin
                // Terminal compare keeps non-power-of-2 depths from wrapping.
                if (cnt_q == CNT_WIDTH'(REGFILE_DEPTH - 1)) begin
                    state_d = RF_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RF_IDLE: begin
                if (Clear_req) begin
                    state_d = RF_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RF_CLEAR;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == RF_CLEAR);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign Clear_busy = busy_q;
    assign clear_addr = cnt_q;
    assign state      = state_q;

endmodule

// File: rtl/id_regfile_mp.sv
// Multi-read-port ID-stage register file with sequential clear engine.
// Define ID_REGFILE_BYPASS_EN to forward same-cycle writes to matching read ports.
module id_regfile_mp
    import RV32I_definitions::*;
#(
    parameter int REG_DATA_WIDTH     = REG_DATA_WIDTH_DEF,
    parameter int REGFILE_ADDR_WIDTH = REGFILE_ADDR_WIDTH_DEF,
    parameter int REGFILE_DEPTH      = REGFILE_DEPTH_DEF,
    parameter int NUM_RD_PORTS       = 2,
    parameter int ZERO_REG           = 1
) (
    input  logic                                       Clk,
    input  logic                                       Reset_n,
    input  logic [NUM_RD_PORTS*REGFILE_ADDR_WIDTH-1:0] Rs_addr,
    output logic [NUM_RD_PORTS*REG_DATA_WIDTH-1:0]     Rs_data,
    input  logic [REGFILE_ADDR_WIDTH-1:0]              Rd_addr,
    input  logic [REG_DATA_WIDTH-1:0]                  Rd_wr_data,
    input  logic                                       Rd_wr_en,
    output logic                                       Wr_ready,
    input  logic                                       Clear_req,
    output logic                                       Clear_busy
);

    localparam int DW = REG_DATA_WIDTH;
    localparam int AW = REGFILE_ADDR_WIDTH;
    localparam int CW = $clog2(REGFILE_DEPTH);

    logic [DW-1:0]  mem_q [REGFILE_DEPTH];
    logic           busy;
    logic [CW-1:0]  clear_addr;
    regfile_state_t rf_state;

    logic           wr_addr_ok;
    logic           wr_fire;
    logic           mem_we;
    logic [CW-1:0]  mem_waddr;
    logic [DW-1:0]  mem_wdata;

    id_regfile_clear_seq #(
        .REGFILE_DEPTH (REGFILE_DEPTH),
        .CNT_WIDTH     (CW)
    ) u_clear_seq (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Clear_req  (Clear_req),
        .Clear_busy (busy),
        .clear_addr (clear_addr),
        .state      (rf_state)
    );

    assign Clear_busy = busy;
    assign Wr_ready   = !busy;

    assign wr_addr_ok = addr_in_range(32'(Rd_addr), REGFILE_DEPTH)
                        && !((ZERO_REG != 0) && (Rd_addr == '0));
    assign wr_fire    = Rd_wr_en && !busy && wr_addr_ok;

    // Clear steps own the write port; user writes are blocked while clearing anyway.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (rf_state == RF_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clear_addr;
        end else if (wr_fire) begin
            mem_we    = 1'b1;
            mem_waddr = Rd_addr[CW-1:0];
            mem_wdata = Rd_wr_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar g = 0; g < NUM_RD_PORTS; g++) begin : g_rd
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;

        assign ra = Rs_addr[g*AW +: AW];

        // Masking wins over bypass so x0 and out-of-range ports always read 0.
        always_comb begin
            rd = mem_q[ra[CW-1:0]];
            if (busy || !addr_in_range(32'(ra), REGFILE_DEPTH)
                || ((ZERO_REG != 0) && (ra == '0))) begin
                rd = '0;
            end
`ifdef ID_REGFILE_BYPASS_EN
            else if (wr_fire && (Rd_addr == ra)) begin
                rd = Rd_wr_data;
            end
`else
            else begin
                rd = mem_q[ra[CW-1:0]];
            end
`endif
        end

        assign Rs_data[g*DW +: DW] = rd;
    end

endmodule

// File: tb/tb_id_regfile_mp.sv
// Scoreboard bench for id_regfile_mp (3 read ports, depth 32, zero register on).
module tb_id_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;
  localparam int NP = 3;
  localparam int EW = 2 + NP * DW;

  logic              Clk;
  logic              Reset_n;
  logic [NP*AW-1:0]  Rs_addr;
  logic [NP*DW-1:0]  Rs_data;
  logic [AW-1:0]     Rd_addr;
  logic [DW-1:0]     Rd_wr_data;
  logic              Rd_wr_en;
  logic              Wr_ready;
  logic              Clear_req;
  logic              Clear_busy;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  logic [EW-1:0] exp_v;
  logic [EW-1:0] act_v;
  string         exp_n;
  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] bp_val;

  id_regfile_mp #(
    .REG_DATA_WIDTH     (DW),
    .REGFILE_ADDR_WIDTH (AW),
    .REGFILE_DEPTH      (DEPTH),
    .NUM_RD_PORTS       (NP),
    .ZERO_REG           (1)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Rs_addr    (Rs_addr),
    .Rs_data    (Rs_data),
    .Rd_addr    (Rd_addr),
    .Rd_wr_data (Rd_wr_data),
    .Rd_wr_en   (Rd_wr_en),
    .Wr_ready   (Wr_ready),
    .Clear_req  (Clear_req),
    .Clear_busy (Clear_busy)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // driver tasks
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    Rs_addr = {a2, a1, a0};
  endtask

  task automatic push_exp(input string name, input logic busy, input logic ready,
                          input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    exp_q.push_back({busy, ready, d2, d1, d0});
    name_q.push_back(name);
  endtask

  // monitor: outputs are stable at the falling edge between driver updates
  always @(negedge Clk) begin
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      exp_n = name_q.pop_front();
      act_v = {Clear_busy, Wr_ready, Rs_data};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL %s: got busy=%0b ready=%0b rs_data=%h, expected busy=%0b ready=%0b rs_data=%h",
                 exp_n, act_v[EW-1], act_v[EW-2], act_v[NP*DW-1:0],
                 exp_v[EW-1], exp_v[EW-2], exp_v[NP*DW-1:0]);
      end
    end
  end

  initial begin
`ifdef ID_REGFILE_BYPASS_EN
    bp_val = 32'h55;
`else
    bp_val = 32'h0;
`endif
    Reset_n = 1'b0;
    Rs_addr = '0;
    Rd_addr = '0;
    Rd_wr_data = '0;
    Rd_wr_en = 1'b0;
    Clear_req = 1'b0;

    repeat (3) step();
    set_rd(5'd5, 5'd7, 5'd9);
    push_exp("reset_state", 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    step();
    Reset_n = 1'b1;

    // write to x7 held during the whole clear must be dropped
    Rd_addr = 5'd7;
    Rd_wr_data = 32'h1234;
    Rd_wr_en = 1'b1;
    repeat (DEPTH - 1) step();
    push_exp("busy_edge31", 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    step();
    Rd_wr_en = 1'b0;
    push_exp("idle_edge32_x7_dropped", 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);

    Rd_addr = 5'd5;
    Rd_wr_data = 32'hDEADBEEF;
    Rd_wr_en = 1'b1;
    step();
    Rd_wr_en = 1'b0;
    set_rd(5'd5, 5'd5, 5'd5);
    push_exp("x5_after_edge33", 1'b0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    step();

    // zero register: masked in the write cycle and afterwards
    set_rd(5'd0, 5'd0, 5'd0);
    Rd_addr = 5'd0;
    Rd_wr_data = 32'hFFFFFFFF;
    Rd_wr_en = 1'b1;
    push_exp("x0_write_cycle", 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    step();
    Rd_wr_en = 1'b0;
    push_exp("x0_after_write", 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    step();

    Rd_addr = 5'd9;
    Rd_wr_data = 32'hA5A5A5A5;
    Rd_wr_en = 1'b1;
    step();
    Rd_addr = 5'd10;
    Rd_wr_data = 32'h11111111;
    step();
    Rd_addr = 5'd11;
    Rd_wr_data = 32'h22222222;
    step();
    Rd_addr = 5'd12;
    Rd_wr_data = 32'h33333333;
    step();
    Rd_wr_en = 1'b0;
    set_rd(5'd9, 5'd9, 5'd9);
    push_exp("x9_all_ports", 1'b0, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
    step();
    set_rd(5'd10, 5'd11, 5'd12);
    push_exp("distinct_10_11_12", 1'b0, 1'b1, 32'h11111111, 32'h22222222, 32'h33333333);
    step();
    set_rd(5'd12, 5'd10, 5'd11);
    push_exp("distinct_12_10_11", 1'b0, 1'b1, 32'h33333333, 32'h11111111, 32'h22222222);
    step();

    // same-cycle write/read of x3
    set_rd(5'd3, 5'd5, 5'd9);
    Rd_addr = 5'd3;
    Rd_wr_data = 32'h55;
    Rd_wr_en = 1'b1;
    push_exp("x3_same_cycle", 1'b0, 1'b1, bp_val, 32'hDEADBEEF, 32'hA5A5A5A5);
    step();
    Rd_wr_en = 1'b0;
    push_exp("x3_after_edge", 1'b0, 1'b1, 32'h55, 32'hDEADBEEF, 32'hA5A5A5A5);
    step();

    // Clear_req, then reset mid-clear at counter 10
    set_rd(5'd5, 5'd9, 5'd3);
    Clear_req = 1'b1;
    push_exp("pre_clear_req", 1'b0, 1'b1, 32'hDEADBEEF, 32'hA5A5A5A5, 32'h55);
    step();
    Clear_req = 1'b0;
    push_exp("clear_req_busy", 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (10) step();
    Reset_n = 1'b0;
    push_exp("reset_mid_clear", 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    #6;
    Reset_n = 1'b1;
    for (int k = 1; k < DEPTH; k++) begin
      step();
      Clear_req = (k == 5);
    end
    Clear_req = 1'b0;
    push_exp("restart_busy_edge31", 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    step();
    push_exp("restart_idle_edge32", 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    step();
    for (int a = 0; a < DEPTH; a += 3) begin
      set_rd(AW'(a), AW'((a + 1) % DEPTH), AW'((a + 2) % DEPTH));
      push_exp("cleared_readback", 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
      step();
    end

    step();
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
